fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage that replaces the free-running PC increment in the datapath. It owns the program counter, issues requests to a 1-cycle-latency instruction memory, buffers returned words with their PCs in a FIFO_DEPTH-entry queue, and hands them to the decoder over a valid/ready handshake. It also supports redirects (branch/jump/exception) with flush, and a halt input.

## Interface
- ADDRESS_SIZE, 32, PC and instruction-address width
- INSTR_SIZE, 32, instruction word width
- BOOT_ADDRESS, 32'h1000, PC value after reset
- FIFO_DEPTH, 4, fetch-queue entries; power of two, ≥2
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- halt  in  1  high: no new memory requests; queue still drains
- redirect  in  1  high for one cycle: flush and restart at redirect_pc
- redirect_pc  in  ADDRESS_SIZE  new fetch address; bits [1:0] forced to 0
- imem_req  out  1  request strobe to instruction memory
- imem_addr  out  ADDRESS_SIZE  request address (= pc register)
- imem_rdata  in  INSTR_SIZE  instruction data, valid the cycle after imem_req
- out_valid  out  1  queue head available to decoder
- out_ready  in  1  decoder accepts head
- out_instr  out  INSTR_SIZE  head instruction
- out_pc  out  ADDRESS_SIZE  address of head instruction

## Operation
- State: pc, inflight (1 bit), inflight_pc, FIFO of {pc, instr} with rd/wr pointers and count (0..FIFO_DEPTH).
- Reset (reset=0): pc=BOOT_ADDRESS, inflight=0, count=0, pointers=0, FIFO storage=0; outputs imem_req=0, imem_addr=BOOT_ADDRESS, out_valid=0, out_instr=0, out_pc=0. Reset mid-operation discards in-flight and queued words.
- Issue: imem_req = !halt && !redirect && (count + inflight < FIFO_DEPTH). On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4 (wraps modulo 2^ADDRESS_SIZE; 0xFFFFFFFC→0). Otherwise inflight<=0.
- Response: when inflight=1, imem_rdata is pushed with inflight_pc. The credit rule guarantees no overflow; push never dropped.
- Dequeue: out_valid = (count≠0) && !redirect; pop when out_valid && out_ready. Push and pop in the same cycle leave count unchanged; on push into an empty queue the word appears at the head the next cycle (no bypass).
- Redirect: same cycle: imem_req=0, out_valid=0, pops suppressed. At edge: count=0, pointers=0, inflight=0 (the response arriving next cycle is ignored), pc=redirect_pc & ~3. Redirect overrides halt and any simultaneous push/pop.
- Halt: affects only issue; an in-flight response is still pushed.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Cycle 0 = first edge with reset high. Cycle 0: imem_req=1, imem_addr=BOOT_ADDRESS. Cycle 1: word pushed. Cycle 2: out_valid=1, out_pc=BOOT_ADDRESS. Fetch-to-decode latency 2 cycles.
- With out_ready held high and halt low: one instruction per cycle sustained, consecutive PCs.
- Redirect asserted in cycle N: imem_req at redirect_pc in N+1; first out_valid for it in N+3.
- Back-pressure: with out_ready low, issue stops once count+inflight=FIFO_DEPTH; queue holds exactly FIFO_DEPTH words. After out_ready rises, the first freed slot allows one request the next cycle.
- out_instr/out_pc stable while out_valid=1 and out_ready=0.

## Test plan
- Reset release, out_ready=1, imem model returns addr^32'hA5A5A5A5 -> out_pc 0x1000,0x1004,0x1008… one per cycle from cycle 2, matching data, no gaps.
- out_ready=0 for 10 cycles -> exactly 4 words queued (0x1000–0x100C), imem_req low thereafter; out_ready=1 -> those 4 drain in order, then 0x1010 continues without loss or duplication.
- redirect with redirect_pc=0x2003 while queue holds 3 words and one is in flight -> out_valid=0 that cycle, imem_addr=0x2000 next cycle, next delivered out_pc=0x2000; no stale 0x10xx word ever appears.
- halt=1 for 5 cycles mid-stream -> in-flight word still delivered, no requests while halted, fetch resumes at next sequential PC.
- BOOT_ADDRESS=32'hFFFFFFF8 -> delivered PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- reset pulsed low for one cycle with full queue -> out_valid and imem_req drop immediately (asynchronously), restart at BOOT_ADDRESS; repeat with FIFO_DEPTH=2 and 8.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage control, instruction-memory and decoder handshake signals.
interface fetch_unit_if #(
   parameter int ADDRESS_SIZE = 32,
   parameter int INSTR_SIZE   = 32
);
   logic                    halt;
   logic                    redirect;
   logic [ADDRESS_SIZE-1:0] redirect_pc;
   logic                    imem_req;
   logic [ADDRESS_SIZE-1:0] imem_addr;
   logic [INSTR_SIZE-1:0]   imem_rdata;
   logic                    out_valid;
   logic                    out_ready;
   logic [INSTR_SIZE-1:0]   out_instr;
   logic [ADDRESS_SIZE-1:0] out_pc;

   modport master (
      input  halt, redirect, redirect_pc, imem_rdata, out_ready,
      output imem_req, imem_addr, out_valid, out_instr, out_pc
   );

   modport slave (
      output halt, redirect, redirect_pc, imem_rdata, out_ready,
      input  imem_req, imem_addr, out_valid, out_instr, out_pc
   );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing 1-cycle-latency imem requests into a {pc, instr} queue
// drained by the decoder over valid/ready, with redirect/flush and halt.
module fetch_unit #(
   parameter int                      ADDRESS_SIZE = 32,
   parameter int                      INSTR_SIZE   = 32,
   parameter logic [ADDRESS_SIZE-1:0] BOOT_ADDRESS = 32'h1000,
   parameter int                      FIFO_DEPTH   = 4
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [ADDRESS_SIZE-1:0] pc, inflight_pc;
   logic                    inflight;
   logic [PW-1:0]           rd_ptr, wr_ptr;
   logic [CW-1:0]           count;
   logic [CW:0]             used;
   logic [ADDRESS_SIZE-1:0] q_pc [FIFO_DEPTH];
   logic [INSTR_SIZE-1:0]   q_instr [FIFO_DEPTH];
   logic                    issue, pop;

   // Credit counts the word in flight so its response always has a free slot.
   assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
   assign issue = reset && !bus.halt && !bus.redirect && (used < (CW+1)'(FIFO_DEPTH));
   assign pop   = bus.out_valid && bus.out_ready;

   assign bus.imem_req  = issue;
   assign bus.imem_addr = pc;
   assign bus.out_valid = (count != '0) && !bus.redirect;
   assign bus.out_instr = q_instr[rd_ptr];
   assign bus.out_pc    = q_pc[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= BOOT_ADDRESS;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else if (bus.redirect) begin
         // Dropping inflight also discards the stale response due next cycle.
         pc       <= {bus.redirect_pc[ADDRESS_SIZE-1:2], 2'b00};
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= pc;
            pc          <= pc + ADDRESS_SIZE'(4);
         end
         if (inflight) begin
            q_pc[wr_ptr]    <= inflight_pc;
            q_instr[wr_ptr] <= bus.imem_rdata;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(inflight) - CW'(pop);
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table for a depth-4 unit plus in-order delivery monitors on
// depth-4, depth-2 (boot near wrap) and depth-8 units sharing the same stimulus.
module tb_fetch_unit;
   localparam logic [31:0] KEY = 32'hA5A5A5A5;

   typedef struct {
      logic        halt;
      logic        redirect;
      logic        ready;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   logic halt, redirect, out_ready;
   logic [31:0] redirect_pc;
   logic [2:0] req, valid;
   logic [2:0][31:0] addr, opc, oinstr;
   int tests = 0;
   int fails = 0;
   int delivered [3] = '{0, 0, 0};
   vec_t vecs [28];

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] boot_of(input int i);
      return (i == 1) ? 32'hFFFFFFF8 : 32'h1000;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : u
      localparam logic [31:0] BOOT = (g == 1) ? 32'hFFFFFFF8 : 32'h1000;
      localparam int DEPTH = (g == 1) ? 2 : (g == 2) ? 8 : 4;
      logic [31:0] exp_pc;
      fetch_unit_if bus ();
      fetch_unit #(.BOOT_ADDRESS(BOOT), .FIFO_DEPTH(DEPTH)) dut (
         .clk(clk), .reset(reset), .bus(bus)
      );
      assign bus.halt        = halt;
      assign bus.redirect    = redirect;
      assign bus.redirect_pc = redirect_pc;
      assign bus.out_ready   = out_ready;
      assign req[g]    = bus.imem_req;
      assign valid[g]  = bus.out_valid;
      assign addr[g]   = bus.imem_addr;
      assign opc[g]    = bus.out_pc;
      assign oinstr[g] = bus.out_instr;
      always @(posedge clk) bus.imem_rdata <= bus.imem_addr ^ KEY;
      // Every accepted word must be the next sequential PC since reset/redirect.
      always @(negedge clk) begin
         if (!reset) exp_pc = BOOT;
         else if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
         else if (bus.out_valid && out_ready) begin
            chk($sformatf("u%0d_seq_pc", g), bus.out_pc, exp_pc);
            chk($sformatf("u%0d_seq_instr", g), bus.out_instr, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            delivered[g]++;
         end
      end
   end

   task automatic run_row(input int n, input vec_t v);
      halt = v.halt;
      redirect = v.redirect;
      redirect_pc = v.rpc;
      out_ready = v.ready;
      @(negedge clk);
      chk($sformatf("row%0d_req", n), req[0], v.req);
      chk($sformatf("row%0d_addr", n), addr[0], v.addr);
      chk($sformatf("row%0d_valid", n), valid[0], v.valid);
      if (v.valid) chk($sformatf("row%0d_pc", n), opc[0], v.pc);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{0, 0, 1, 0,          1, 32'h1000, 0, 0};
      vecs[1]  = '{0, 0, 1, 0,          1, 32'h1004, 0, 0};
      vecs[2]  = '{0, 0, 1, 0,          1, 32'h1008, 1, 32'h1000};
      vecs[3]  = '{0, 0, 1, 0,          1, 32'h100C, 1, 32'h1004};
      vecs[4]  = '{0, 0, 1, 0,          1, 32'h1010, 1, 32'h1008};
      vecs[5]  = '{0, 0, 1, 0,          1, 32'h1014, 1, 32'h100C};
      vecs[6]  = '{0, 0, 0, 0,          1, 32'h1018, 1, 32'h1010};
      vecs[7]  = '{0, 0, 0, 0,          1, 32'h101C, 1, 32'h1010};
      vecs[8]  = '{0, 0, 0, 0,          0, 32'h1020, 1, 32'h1010};
      vecs[9]  = '{0, 0, 0, 0,          0, 32'h1020, 1, 32'h1010};
      vecs[10] = '{0, 0, 1, 0,          0, 32'h1020, 1, 32'h1010};
      vecs[11] = '{0, 0, 1, 0,          1, 32'h1020, 1, 32'h1014};
      vecs[12] = '{0, 0, 1, 0,          1, 32'h1024, 1, 32'h1018};
      vecs[13] = '{0, 0, 1, 0,          1, 32'h1028, 1, 32'h101C};
      vecs[14] = '{0, 0, 0, 0,          1, 32'h102C, 1, 32'h1020};
      vecs[15] = '{0, 1, 1, 32'h2003,   0, 32'h1030, 0, 0};
      vecs[16] = '{0, 0, 1, 0,          1, 32'h2000, 0, 0};
      vecs[17] = '{0, 0, 1, 0,          1, 32'h2004, 0, 0};
      vecs[18] = '{0, 0, 1, 0,          1, 32'h2008, 1, 32'h2000};
      vecs[19] = '{0, 0, 1, 0,          1, 32'h200C, 1, 32'h2004};
      vecs[20] = '{1, 0, 1, 0,          0, 32'h2010, 1, 32'h2008};
      vecs[21] = '{1, 0, 1, 0,          0, 32'h2010, 1, 32'h200C};
      vecs[22] = '{1, 0, 1, 0,          0, 32'h2010, 0, 0};
      vecs[23] = '{1, 0, 1, 0,          0, 32'h2010, 0, 0};
      vecs[24] = '{1, 0, 1, 0,          0, 32'h2010, 0, 0};
      vecs[25] = '{0, 0, 1, 0,          1, 32'h2010, 0, 0};
      vecs[26] = '{0, 0, 1, 0,          1, 32'h2014, 0, 0};
      vecs[27] = '{0, 0, 1, 0,          1, 32'h2018, 1, 32'h2010};

      reset = 1'b0;
      halt = 1'b0;
      redirect = 1'b0;
      redirect_pc = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_req%0d", i), req[i], 0);
         chk($sformatf("rst_valid%0d", i), valid[i], 0);
         chk($sformatf("rst_addr%0d", i), addr[i], boot_of(i));
         chk($sformatf("rst_pc%0d", i), opc[i], 0);
         chk($sformatf("rst_instr%0d", i), oinstr[i], 0);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 28; i++) run_row(i, vecs[i]);
      chk("u1_wrap_delivered", delivered[1] >= 3, 1);

      // Fill every queue under back-pressure; head must hold still.
      out_ready = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("full_valid", valid[0], 1);
      chk("full_head", opc[0], 32'h2014);
      chk("full_addr", addr[0], 32'h2024);
      for (int i = 0; i < 3; i++) chk($sformatf("full_req%0d", i), req[i], 0);

      // Asynchronous reset pulse mid-cycle with full queues.
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("arst_req%0d", i), req[i], 0);
         chk($sformatf("arst_valid%0d", i), valid[i], 0);
         chk($sformatf("arst_addr%0d", i), addr[i], boot_of(i));
      end
      @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 6; i++) run_row(i, vecs[i]);

      // Redirect overrides a simultaneous halt.
      halt = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h3001;
      @(negedge clk);
      chk("rh_req", req[0], 0);
      chk("rh_valid", valid[0], 0);
      @(posedge clk);
      #1;
      halt = 1'b0;
      redirect = 1'b0;
      @(negedge clk);
      chk("rh_addr", addr[0], 32'h3000);
      chk("rh_req_after", req[0], 1);
      repeat (8) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
